// File: rtl/dc617_clk_pkg.sv
// Shared encodings for the DC617 console clock-step sequencer: FSM states,
// SAC clock-control codes and console command codes.
package dc617_clk_pkg;

    typedef logic [2:0] state_t;
    localparam state_t ST_STOPPED  = 3'd0;
    localparam state_t ST_RUN      = 3'd1;
    localparam state_t ST_STOPPING = 3'd2;
    localparam state_t ST_ARM      = 3'd3;
    localparam state_t ST_ISSUE    = 3'd4;
    localparam state_t ST_WAIT     = 3'd5;

    typedef logic [1:0] clk_code_t;
    localparam clk_code_t CLK_STOP  = 2'd0;
    localparam clk_code_t CLK_STEPB = 2'd1;
    localparam clk_code_t CLK_STEPM = 2'd2;
    localparam clk_code_t CLK_RUN   = 2'd3;

    typedef logic [1:0] cmd_t;
    localparam cmd_t CMD_HALT  = 2'd0;
    localparam cmd_t CMD_RUN   = 2'd1;
    localparam cmd_t CMD_STEPM = 2'd2;
    localparam cmd_t CMD_STEPB = 2'd3;

    function automatic clk_code_t step_code(input cmd_t cmd);
        return (cmd == CMD_STEPM) ? CLK_STEPM : CLK_STEPB;
    endfunction

    function automatic clk_code_t state_code(input state_t st, input clk_code_t step);
        case (st)
            ST_RUN:            return CLK_RUN;
            ST_ISSUE, ST_WAIT: return step;
            default:           return CLK_STOP;
        endcase
    endfunction

endpackage

// File: rtl/dc617_clk_wdog.sv
// Watchdog for the clock-step sequencer: counts cycles spent waiting on the
// SAC and flags expiry when the TIMEOUT-th waiting cycle completes.
module dc617_clk_wdog #(
    parameter int TIMEOUT = 4095
) (
    input  logic base_clk_h,
    input  logic init_l,
    input  logic clr_h,
    input  logic en_h,
    output logic expire_h
);

    logic [11:0] count_reg;

    assign expire_h = en_h && (count_reg == 12'(TIMEOUT - 1));

    always_ff @(posedge base_clk_h or negedge init_l) begin
        if (!init_l) begin
            count_reg <= '0;
        end else if (clr_h) begin
            count_reg <= '0;
        end else if (en_h && !expire_h) begin
            count_reg <= count_reg + 12'd1;
        end
    end

endmodule

// File: rtl/dc617_clk_step_ctl.sv
// Console-side clock control sequencer for the SAC: turns HALT/RUN/STEPM/STEPB
// commands into the SAC clock-control code and tracks halt_l for completion.
module dc617_clk_step_ctl
    import dc617_clk_pkg::*;
#(
    parameter int ARM_CYCLES = 2,
    parameter int TIMEOUT    = 4095
) (
    input  logic       base_clk_h,
    input  logic       init_l,
    input  logic       cmd_valid_h,
    input  logic [1:0] cmd_h,
    input  logic [7:0] cmd_count_h,
    output logic       cmd_ready_h,
    input  logic       halt_l,
    output logic [1:0] clk_ctl_h,
    output logic       done_h,
    output logic       run_h,
    output logic [7:0] steps_left_h,
    output logic       timeout_h,
    output logic       err_halt_h
);

    localparam int ARM_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;

    state_t          state_reg, state_next;
    clk_code_t       step_code_reg, step_code_next;
    clk_code_t       clk_ctl_reg;
    logic [7:0]      steps_left_reg, steps_left_next;
    logic [ARM_W-1:0] arm_cnt_reg, arm_cnt_next;
    logic            done_reg, done_next;
    logic            timeout_reg, timeout_next;
    logic            err_halt_reg, err_halt_next;
    logic            halt_q_reg;
    logic            run_seen_reg, run_seen_next;
    logic            run_low_reg, run_low_next;
    logic            accept;
    logic            wdog_clr, wdog_en, wdog_expire;

    assign cmd_ready_h  = (state_reg == ST_STOPPED) || (state_reg == ST_RUN);
    assign run_h        = (state_reg == ST_RUN);
    assign clk_ctl_h    = clk_ctl_reg;
    assign done_h       = done_reg;
    assign steps_left_h = steps_left_reg;
    assign timeout_h    = timeout_reg;
    assign err_halt_h   = err_halt_reg;

    assign accept   = cmd_valid_h && cmd_ready_h;
    assign wdog_clr = (state_next != state_reg);
    assign wdog_en  = (state_reg == ST_STOPPING) || (state_reg == ST_ISSUE) ||
                      (state_reg == ST_WAIT);

    dc617_clk_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .base_clk_h (base_clk_h),
        .init_l     (init_l),
        .clr_h      (wdog_clr),
        .en_h       (wdog_en),
        .expire_h   (wdog_expire)
    );

    always_comb begin
        state_next      = state_reg;
        step_code_next  = step_code_reg;
        steps_left_next = steps_left_reg;
        done_next       = 1'b0;
        timeout_next    = timeout_reg;
        err_halt_next   = err_halt_reg;

        if (accept) begin
            timeout_next  = 1'b0;
            err_halt_next = 1'b0;
        end

        case (state_reg)
            ST_STOPPED: begin
                if (accept) begin
                    case (cmd_h)
                        CMD_HALT: done_next  = 1'b1;
                        CMD_RUN:  state_next = ST_RUN;
                        default: begin
                            steps_left_next = (cmd_count_h == 8'd0) ? 8'd1 : cmd_count_h;
                            step_code_next  = step_code(cmd_h);
                            state_next      = ST_ARM;
                        end
                    endcase
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (cmd_h == CMD_RUN) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = ST_STOPPING;
                    end
                end else if (run_seen_reg && run_low_reg && !halt_q_reg) begin
                    err_halt_next = 1'b1;
                    state_next    = ST_STOPPED;
                end
            end
            ST_STOPPING: begin
                if (!halt_q_reg) begin
                    done_next  = 1'b1;
                    state_next = ST_STOPPED;
                end
            end
            ST_ARM: begin
                if (arm_cnt_reg == ARM_W'(ARM_CYCLES - 1)) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (halt_q_reg) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!halt_q_reg) begin
                    if (steps_left_reg != 8'd0) begin
                        steps_left_next = steps_left_reg - 8'd1;
                    end
                    if (steps_left_reg <= 8'd1) begin
                        done_next  = 1'b1;
                        state_next = ST_STOPPED;
                    end else begin
                        state_next = ST_ARM;
                    end
                end
            end
            default: state_next = ST_STOPPED;
        endcase

        // Expiry only acts while still stuck waiting; a real SAC response wins.
        if (wdog_expire && (state_next == state_reg)) begin
            timeout_next    = 1'b1;
            steps_left_next = 8'd0;
            state_next      = ST_STOPPED;
        end

        arm_cnt_next = (state_next != state_reg) ? '0 :
                       (state_reg == ST_ARM) ? arm_cnt_reg + ARM_W'(1) : arm_cnt_reg;

        // The SAC is still halted on RUN entry, so the unsolicited-halt check
        // only arms once the SAC has been seen running in this RUN stint.
        run_seen_next = (state_next == ST_RUN) && (run_seen_reg || halt_q_reg);
        run_low_next  = (state_reg == ST_RUN) && (state_next == ST_RUN) &&
                        run_seen_reg && !halt_q_reg && !accept;
    end

    // clk_ctl follows state one cycle late, so each ARM stint yields an equally
    // long STOP window directly ahead of the step code.
    always_ff @(posedge base_clk_h or negedge init_l) begin
        if (!init_l) begin
            state_reg      <= ST_STOPPED;
            step_code_reg  <= CLK_STOP;
            clk_ctl_reg    <= CLK_STOP;
            steps_left_reg <= 8'd0;
            arm_cnt_reg    <= '0;
            done_reg       <= 1'b0;
            timeout_reg    <= 1'b0;
            err_halt_reg   <= 1'b0;
            halt_q_reg     <= 1'b0;
            run_seen_reg   <= 1'b0;
            run_low_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            step_code_reg  <= step_code_next;
            clk_ctl_reg    <= state_code(state_reg, step_code_reg);
            steps_left_reg <= steps_left_next;
            arm_cnt_reg    <= arm_cnt_next;
            done_reg       <= done_next;
            timeout_reg    <= timeout_next;
            err_halt_reg   <= err_halt_next;
            halt_q_reg     <= halt_l;
            run_seen_reg   <= run_seen_next;
            run_low_reg    <= run_low_next;
        end
    end

endmodule
